// File: rtl/fu_pkg.sv
// Shared definitions for the FU arbiter.
//   - FSM state encoding (IDLE/EXEC/RESP) and its typed enum
//   - FS field positions: FS = {MF, S[2:0], Cin}; bits [4:2] equal to FS_UNDEF mark an undefined op
//   - response flag bit order {Z,N,C,V}
package fu_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StExec = EXEC,
        StResp = RESP
    } fu_state_e;

    localparam int unsigned FS_W      = 5;
    localparam int unsigned FS_OP_HI  = 4;
    localparam int unsigned FS_OP_LO  = 2;
    localparam logic [2:0]  FS_UNDEF  = 3'b111;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    function automatic logic fs_is_undef(input logic [FS_W-1:0] fs);
        return fs[FS_OP_HI:FS_OP_LO] == FS_UNDEF;
    endfunction

    function automatic logic [3:0] pack_flags(input logic z, input logic n, input logic c,
                                              input logic v);
        logic [3:0] flags;
        flags         = '0;
        flags[FLAG_Z] = z;
        flags[FLAG_N] = n;
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
        return flags;
    endfunction

endpackage

// File: rtl/fu_arb_grant.sv
// Two-way grant for the FU arbiter.
// Build option: FU_ARB_RR_EN selects round-robin; otherwise fixed priority (req0 wins).
// Ports:
//   clk_i, rst_ni    clock / synchronous active-low reset (round-robin build only)
//   accept_i         a granted request was accepted this cycle (round-robin build only)
//   req0_valid_i     requester 0 valid
//   req1_valid_i     requester 1 valid
//   gnt_o            granted requester index (0 or 1), combinational
module fu_arb_grant (
`ifdef FU_ARB_RR_EN
    input  logic clk_i,
    input  logic rst_ni,
    input  logic accept_i,
`endif
    input  logic req0_valid_i,
    input  logic req1_valid_i,
    output logic gnt_o
);

`ifdef FU_ARB_RR_EN
    // Reset value 1 makes the first contended grant go to req0.
    logic last_gnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_gnt_q <= 1'b1;
        end else if (accept_i) begin
            last_gnt_q <= gnt_o;
        end
    end

    always_comb begin
        if (req0_valid_i && req1_valid_i) begin
            gnt_o = ~last_gnt_q;
        end else if (req1_valid_i) begin
            gnt_o = 1'b1;
        end else if (req0_valid_i) begin
            gnt_o = 1'b0;
        end else begin
            gnt_o = ~last_gnt_q;
        end
    end
`else
    assign gnt_o = req1_valid_i & ~req0_valid_i;
`endif

endmodule

// File: rtl/fu_arbiter.sv
// Shares one external combinational function unit between two requesters.
// Accepts one request, drives the FU from latched operands for one cycle, registers the result
// and flags, then presents them on a valid/ready response channel tagged with the requester id.
// Build option: FU_ARB_RR_EN enables round-robin arbitration (default: fixed priority, req0 wins).
// Ports:
//   uclk, rst_n                     clock, synchronous active-low reset
//   reqN_valid/ready (N=0,1)        request handshake; payload reqN_fs/a/b/sh held until accepted
//   fu_fs/fu_a/fu_b/fu_sh           to the FU, latched operands (hold outside EXEC)
//   fu_f, fu_v/c/n/z                from the FU
//   rsp_valid/rsp_ready             response handshake
//   rsp_id, rsp_f, rsp_flags, rsp_err  response payload; flags are {Z,N,C,V}
//   busy                            FSM not idle
//   op_cnt                          responses delivered, wraps silently
module fu_arbiter
    import fu_pkg::*;
#(
    parameter int unsigned word_Size = 32,
    parameter int unsigned cnt_Size  = 16
) (
    input  logic                 uclk,
    input  logic                 rst_n,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [4:0]           req0_fs,
    input  logic [word_Size-1:0] req0_a,
    input  logic [word_Size-1:0] req0_b,
    input  logic [4:0]           req0_sh,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [4:0]           req1_fs,
    input  logic [word_Size-1:0] req1_a,
    input  logic [word_Size-1:0] req1_b,
    input  logic [4:0]           req1_sh,

    output logic [4:0]           fu_fs,
    output logic [word_Size-1:0] fu_a,
    output logic [word_Size-1:0] fu_b,
    output logic [4:0]           fu_sh,
    input  logic [word_Size-1:0] fu_f,
    input  logic                 fu_v,
    input  logic                 fu_c,
    input  logic                 fu_n,
    input  logic                 fu_z,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [word_Size-1:0] rsp_f,
    output logic [3:0]           rsp_flags,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [cnt_Size-1:0]  op_cnt
);

    fu_state_e            state_q;
    logic [4:0]           fs_q;
    logic [4:0]           sh_q;
    logic [word_Size-1:0] a_q;
    logic [word_Size-1:0] b_q;
    logic                 id_q;
    logic [word_Size-1:0] rsp_f_q;
    logic [3:0]           rsp_flags_q;
    logic                 rsp_err_q;
    logic                 rsp_valid_q;
    logic [cnt_Size-1:0]  op_cnt_q;

    logic gnt;
    logic idle;
    logic accept;

    fu_arb_grant u_grant (
`ifdef FU_ARB_RR_EN
        .clk_i        (uclk),
        .rst_ni       (rst_n),
        .accept_i     (accept),
`endif
        .req0_valid_i (req0_valid),
        .req1_valid_i (req1_valid),
        .gnt_o        (gnt)
    );

    assign idle       = (state_q == StIdle);
    assign req0_ready = idle & ~gnt;
    assign req1_ready = idle & gnt;
    assign accept     = (req0_ready & req0_valid) | (req1_ready & req1_valid);

    always_ff @(posedge uclk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            fs_q        <= '0;
            sh_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_f_q     <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            op_cnt_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        fs_q    <= gnt ? req1_fs : req0_fs;
                        sh_q    <= gnt ? req1_sh : req0_sh;
                        a_q     <= gnt ? req1_a  : req0_a;
                        b_q     <= gnt ? req1_b  : req0_b;
                        id_q    <= gnt;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    // Undefined ops report an error with a zeroed result, whatever the FU says.
                    if (fs_is_undef(fs_q)) begin
                        rsp_f_q     <= '0;
                        rsp_flags_q <= '0;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        rsp_f_q     <= fu_f;
                        rsp_flags_q <= pack_flags(fu_z, fu_n, fu_c, fu_v);
                        rsp_err_q   <= 1'b0;
                    end
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_cnt_q    <= op_cnt_q + cnt_Size'(1);
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign fu_fs     = fs_q;
    assign fu_a      = a_q;
    assign fu_b      = b_q;
    assign fu_sh     = sh_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_f     = rsp_f_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = ~idle;
    assign op_cnt    = op_cnt_q;

endmodule
